// File: rtl/dec_pkg.sv
// Shared encodings for the decode stage: immediate modes, write-back
// sources and the bit positions of the instruction fields.
package dec_pkg;

   typedef enum logic [1:0] {
      IMM_SEXT     = 2'b00,
      IMM_ZFILL    = 2'b01,
      IMM_HI16     = 2'b10,
      IMM_SEXT_SL2 = 2'b11
   } imm_sel_e;

   // Code 2'b11 is deliberately left out; it falls back to the ALU result.
   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10
   } wb_sel_e;

   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 26;
   localparam int RS_HI     = 25;
   localparam int RS_LO     = 21;
   localparam int RD_HI     = 20;
   localparam int RD_LO     = 16;
   localparam int RT_HI     = 15;
   localparam int RT_LO     = 11;
   localparam int IMM_HI    = 15;
   localparam int IMM_LO    = 0;

endpackage

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one
// synchronous write port, r0 hardwired to zero, write-to-read bypass.
module reg_file_param #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   localparam int NREG = 2**REG_AW;

   logic [DATA_W-1:0] regs [NREG];

   // Storage: reset clears every entry; writes to r0 are dropped so it stays zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Read ports: r0 reads zero, a same-cycle write to the read address is forwarded.
   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (raddr_a != '0) begin
         rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
      end
      if (raddr_b != '0) begin
         rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
      end
   end

endmodule

// File: rtl/decode_stage_param.sv
// Decode stage of the multi-cycle MIPS datapath: register file, immediate
// extender, write-back mux and the operand latch with its valid pulse.
module decode_stage_param #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int LINK_REG = 31
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [31:0]       Instr,
   input  logic              Dec_En,
   input  logic              RF_B_sel,
   input  logic [1:0]        Imm_sel,
   input  logic              RF_WrEn,
   input  logic [1:0]        RF_WrData_sel,
   input  logic              Wr_dst_sel,
   input  logic [DATA_W-1:0] ALU_out,
   input  logic [DATA_W-1:0] MEM_out,
   input  logic [DATA_W-1:0] PC_plus4,
   output logic [DATA_W-1:0] RF_A,
   output logic [DATA_W-1:0] RF_B,
   output logic [DATA_W-1:0] Immed,
   output logic              Dec_Valid
);

   import dec_pkg::*;

   localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);

   logic [REG_AW-1:0] rs_addr;
   logic [REG_AW-1:0] rd_addr;
   logic [REG_AW-1:0] rt_addr;
   logic [REG_AW-1:0] b_addr;
   logic [REG_AW-1:0] waddr;
   logic [15:0]       imm;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic              unused_opcode;

   // The opcode belongs to the control unit; it is not decoded here.
   assign unused_opcode = ^Instr[OPCODE_HI:OPCODE_LO];

   // Register fields are resized to the configured address width.
   assign rs_addr = REG_AW'(Instr[RS_HI:RS_LO]);
   assign rd_addr = REG_AW'(Instr[RD_HI:RD_LO]);
   assign rt_addr = REG_AW'(Instr[RT_HI:RT_LO]);
   assign b_addr  = RF_B_sel ? rd_addr : rt_addr;
   assign waddr   = Wr_dst_sel ? LINK_ADDR : rd_addr;

   assign imm      = Instr[IMM_HI:IMM_LO];
   assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};

   // Immediate extension; the shifted modes start from the sign-extended
   // value so the bits above bit 31 follow the immediate's sign.
   always_comb begin
      imm_ext = imm_sext;
      case (imm_sel_e'(Imm_sel))
         IMM_SEXT:     imm_ext = imm_sext;
         IMM_ZFILL:    imm_ext = {{(DATA_W-16){1'b0}}, imm};
         IMM_HI16:     imm_ext = imm_sext << 16;
         IMM_SEXT_SL2: imm_ext = imm_sext << 2;
         default:      imm_ext = imm_sext;
      endcase
   end

   // Write-back source select; the unused code falls back to the ALU result.
   always_comb begin
      wdata = ALU_out;
      case (wb_sel_e'(RF_WrData_sel))
         WB_MEM:  wdata = MEM_out;
         WB_PC4:  wdata = PC_plus4;
         default: wdata = ALU_out;
      endcase
   end

   reg_file_param #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_reg_file (
      .clk     (Clk),
      .rst     (Rst),
      .raddr_a (rs_addr),
      .raddr_b (b_addr),
      .we      (RF_WrEn),
      .waddr   (waddr),
      .wdata   (wdata),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b)
   );

   // Operand latch: capture on Dec_En, hold otherwise, pulse valid for one cycle.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         RF_A      <= '0;
         RF_B      <= '0;
         Immed     <= '0;
         Dec_Valid <= 1'b0;
      end else begin
         Dec_Valid <= Dec_En;
         if (Dec_En) begin
            RF_A  <= rdata_a;
            RF_B  <= rdata_b;
            Immed <= imm_ext;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage_param.sv
// Directed bench for decode_stage_param: a 32-bit/32-register instance checked
// through an expected-operand queue, plus a 64-bit/8-register instance for the
// wide immediate and reset-during-latch cases.
module tb_decode_stage_param;

   typedef struct {
      string       tag;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] Instr;
   logic        Dec_En;
   logic        RF_B_sel;
   logic [1:0]  Imm_sel;
   logic        RF_WrEn;
   logic [1:0]  RF_WrData_sel;
   logic        Wr_dst_sel;
   logic [31:0] ALU_out;
   logic [31:0] MEM_out;
   logic [31:0] PC_plus4;
   logic [31:0] RF_A;
   logic [31:0] RF_B;
   logic [31:0] Immed;
   logic        Dec_Valid;

   logic [63:0] w_alu_out;
   logic [63:0] w_mem_out;
   logic [63:0] w_pc_plus4;
   logic [63:0] w_rf_a;
   logic [63:0] w_rf_b;
   logic [63:0] w_immed;
   logic        w_dec_valid;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 Clk = ~Clk;

   decode_stage_param #(.DATA_W(32), .REG_AW(5), .LINK_REG(31)) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Instr         (Instr),
      .Dec_En        (Dec_En),
      .RF_B_sel      (RF_B_sel),
      .Imm_sel       (Imm_sel),
      .RF_WrEn       (RF_WrEn),
      .RF_WrData_sel (RF_WrData_sel),
      .Wr_dst_sel    (Wr_dst_sel),
      .ALU_out       (ALU_out),
      .MEM_out       (MEM_out),
      .PC_plus4      (PC_plus4),
      .RF_A          (RF_A),
      .RF_B          (RF_B),
      .Immed         (Immed),
      .Dec_Valid     (Dec_Valid)
   );

   decode_stage_param #(.DATA_W(64), .REG_AW(3), .LINK_REG(31)) dut_wide (
      .Clk           (Clk),
      .Rst           (Rst),
      .Instr         (Instr),
      .Dec_En        (Dec_En),
      .RF_B_sel      (RF_B_sel),
      .Imm_sel       (Imm_sel),
      .RF_WrEn       (RF_WrEn),
      .RF_WrData_sel (RF_WrData_sel),
      .Wr_dst_sel    (Wr_dst_sel),
      .ALU_out       (w_alu_out),
      .MEM_out       (w_mem_out),
      .PC_plus4      (w_pc_plus4),
      .RF_A          (w_rf_a),
      .RF_B          (w_rf_b),
      .Immed         (w_immed),
      .Dec_Valid     (w_dec_valid)
   );

   // One comparison: counts it, and on a miss counts the failure and reports it.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's worth of controls; optionally queue the operands this latch must produce.
   task automatic applyStimulus(input logic [31:0] instr, input logic dec_en,
                                input logic [1:0] imm_sel, input logic b_sel,
                                input logic wr_en, input logic [1:0] wb_sel,
                                input logic dst_sel, input string tag,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [31:0] eimm);
      exp_t e;
      Instr         = instr;
      Dec_En        = dec_en;
      Imm_sel       = imm_sel;
      RF_B_sel      = b_sel;
      RF_WrEn       = wr_en;
      RF_WrData_sel = wb_sel;
      Wr_dst_sel    = dst_sel;
      if (dec_en && !Rst) begin
         e.tag = tag;
         e.a   = ea;
         e.b   = eb;
         e.imm = eimm;
         sb.push_back(e);
      end
      @(posedge Clk);
      #1;
   endtask

   // Scoreboard: every valid pulse must match the oldest queued expectation.
   always @(negedge Clk) begin
      if (Dec_Valid === 1'b1) begin
         checks++;
         assert (sb.size() != 0)
         else begin
            errors++;
            $error("[TB] FAIL unexpected_valid observed=1 expected=0 (queue empty)");
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput({e.tag, "_A"}, {32'h0, RF_A}, {32'h0, e.a});
            checkOutput({e.tag, "_B"}, {32'h0, RF_B}, {32'h0, e.b});
            checkOutput({e.tag, "_Imm"}, {32'h0, Immed}, {32'h0, e.imm});
         end
      end
   end

   initial begin
      Rst = 1'b1;
      ALU_out = '0; MEM_out = '0; PC_plus4 = '0;
      w_alu_out = '0; w_mem_out = '0; w_pc_plus4 = '0;
      applyStimulus(32'h0000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "", '0, '0, '0);
      // Second reset cycle carries a write to r8 and a latch; reset must win.
      ALU_out = 32'hDEAD_BEEF;
      applyStimulus(32'h0108_1234, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, "", '0, '0, '0);
      checkOutput("reset_valid", {63'h0, Dec_Valid}, 64'h0);
      checkOutput("reset_A", {32'h0, RF_A}, 64'h0);
      checkOutput("reset_Imm", {32'h0, Immed}, 64'h0);
      Rst = 1'b0;

      // Latch rs=8 straight after reset: the discarded write left r8 at zero.
      applyStimulus(32'h0100_0000, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "r8_after_reset", 32'h0, 32'h0, 32'h0);
      checkOutput("valid_pulse_hi", {63'h0, Dec_Valid}, 64'h1);
      applyStimulus(32'h0100_0000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "", '0, '0, '0);
      checkOutput("valid_pulse_lo", {63'h0, Dec_Valid}, 64'h0);

      // Write all-ones to r0 with a concurrent latch of r0, then read r0 again.
      ALU_out = 32'hFFFF_FFFF;
      applyStimulus(32'h0000_0000, 1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, "r0_bypass_blocked", 32'h0, 32'h0, 32'h0);
      applyStimulus(32'h0000_0000, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "r0_read", 32'h0, 32'h0, 32'h0);

      // Write r8 from the memory path, then sign-extend latch, then read r8.
      MEM_out = 32'h739D_2C40;
      applyStimulus(32'h0008_0000, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, "", '0, '0, '0);
      applyStimulus(32'hE22D_DD8F, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "sext", 32'h0, 32'h0, 32'hFFFF_DD8F);
      applyStimulus(32'h0100_0000, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "r8_mem_write", 32'h739D_2C40, 32'h0, 32'h0);

      // Zero-fill with a same-edge write to r26 that B reads through rd.
      ALU_out = 32'h884E_2B59;
      applyStimulus(32'hCD1A_5D8F, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, "zfill_bypass", 32'h739D_2C40, 32'h884E_2B59, 32'h0000_5D8F);
      applyStimulus(32'h0340_0000, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, "r26_stored", 32'h884E_2B59, 32'h0, 32'h0);

      // Shift modes back to back; valid must stay high across both.
      applyStimulus(32'h0000_8001, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, "hi16", 32'h0, 32'h0, 32'h8001_0000);
      checkOutput("b2b_valid_1", {63'h0, Dec_Valid}, 64'h1);
      applyStimulus(32'h0000_8001, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, "sext_sl2", 32'h0, 32'h0, 32'hFFFE_0004);
      checkOutput("b2b_valid_2", {63'h0, Dec_Valid}, 64'h1);

      // Link write to r31 (rd=5 must stay untouched), then read rs=31 and rd=5.
      PC_plus4 = 32'h0000_0104;
      applyStimulus(32'h0005_0000, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, "", '0, '0, '0);
      applyStimulus(32'h03E5_0000, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, "link_read", 32'h0000_0104, 32'h0, 32'h0);
      applyStimulus(32'h0000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "", '0, '0, '0);
      checkOutput("hold_A", {32'h0, RF_A}, 64'h0000_0104);

      // Write-back code 11 takes the ALU result, not memory.
      ALU_out = 32'h1234_5678;
      MEM_out = 32'hCAFE_F00D;
      applyStimulus(32'h0009_0000, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, "", '0, '0, '0);
      applyStimulus(32'h0120_0000, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "wb11_alias", 32'h1234_5678, 32'h0, 32'h0);

      // Wide instance: sign extension and high-half mode above bit 31.
      applyStimulus(32'hE22D_DD8F, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "sext_pre_reset", 32'h0, 32'h0, 32'hFFFF_DD8F);
      checkOutput("wide_sext", w_immed, 64'hFFFF_FFFF_FFFF_DD8F);
      applyStimulus(32'h0000_8001, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, "hi16_pre_reset", 32'h0, 32'h0, 32'h8001_0000);
      checkOutput("wide_hi16", w_immed, 64'hFFFF_FFFF_8001_0000);

      // Reset together with Dec_En: no latch, outputs cleared on both instances.
      Rst = 1'b1;
      applyStimulus(32'hE22D_DD8F, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "", '0, '0, '0);
      checkOutput("midrst_valid", {63'h0, Dec_Valid}, 64'h0);
      checkOutput("midrst_Imm", {32'h0, Immed}, 64'h0);
      checkOutput("midrst_wide_valid", {63'h0, w_dec_valid}, 64'h0);
      checkOutput("midrst_wide_Imm", w_immed, 64'h0);
      checkOutput("midrst_wide_A", w_rf_a, 64'h0);
      Rst = 1'b0;

      // After reset: r8 is cleared again and the wide immediate sign-extends.
      applyStimulus(32'h0100_DD8F, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "post_reset", 32'h0, 32'h0, 32'hFFFF_DD8F);
      checkOutput("post_wide_valid", {63'h0, w_dec_valid}, 64'h1);
      checkOutput("post_wide_sext", w_immed, 64'hFFFF_FFFF_FFFF_DD8F);
      applyStimulus(32'h0000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, "", '0, '0, '0);
      @(negedge Clk);
      #1;
      checkOutput("queue_drained", 64'(sb.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
